mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit with HI/LO result registers, parametrised in operand width, for the multicycle MIPS core. It executes MULT, MULTU, DIV and DIVU over WIDTH+2 clock edges behind a start/busy/done handshake. It holds results in HI/LO for MFHI/MFLO, and accepts MTHI/MTLO writes. The core controller holds its FSM in a wait state while `busy` is high; operands come from the register-file read ports.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each WIDTH bits. Legal range is WIDTH ≥ 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  launches the operation selected by `op`; sampled only while `busy`=0.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  multiplicand or dividend (rs).
- `b`  in  WIDTH  multiplier or divisor (rt).
- `hi_we`  in  1  MTHI: write `wdata` into HI.
- `lo_we`  in  1  MTLO: write `wdata` into LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse; HI/LO were updated at the preceding edge.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states:
  - IDLE → CALC on `start`.
  - CALC runs for WIDTH iterations using a counter `cnt` from 0 to WIDTH-1.
  - CALC → FIX when `cnt`=WIDTH-1.
  - FIX → IDLE unconditionally.
- Start edge:
  - Latch `op` and the operand magnitudes: for signed ops, |a| and |b| in WIDTH+1 bits; for unsigned ops, a and b zero-extended.
  - Latch the sign flags sa and sb; both are 0 for unsigned ops.
  - Clear the working accumulators.
  - Later changes on `a`, `b` and `op` have no effect.
- Multiply: radix-2 shift-add on the magnitudes, one multiplier bit per CALC cycle, into a 2·WIDTH-bit accumulator.
- Divide: restoring division, one quotient bit per CALC cycle, with a WIDTH+1-bit partial remainder.
- FIX edge writes the sign-corrected result:
  - Multiply: {HI,LO} = product, negated if sa^sb.
  - Divide: LO = quotient, negated if sa^sb; HI = remainder, negated if sa. The remainder takes the dividend's sign.
- The unit pulses `done` for the cycle after the FIX edge.
- Divide by zero (b=0):
  - Takes the full latency.
  - Result is HI = original a, LO = all ones, for both DIV and DIVU.
- Signed overflow (DIV with a=100…0, b=all ones): LO = 100…0, HI = 0. This is the natural result of magnitude arithmetic truncated to WIDTH bits; no special case is needed.
- MTHI/MTLO:
  - In IDLE, `hi_we`/`lo_we` write `wdata` at the edge. Both may be asserted together, in which case both registers take `wdata`.
  - While `busy`, they are ignored.
  - If `start` and a write are both asserted in IDLE, `start` wins and the write is dropped.
- `start` while busy is ignored; it is neither queued nor restarted.
- HI/LO are not modified at the start edge or during CALC. Their old values stay readable until the FIX edge.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, `cnt`=0, accumulators 0.
- Reset asserted mid-operation aborts immediately: outputs take their reset values, the operation is lost and no `done` pulse is generated.
- Edge E0 samples `start`=1. `busy`=1 from E0 through E(WIDTH+1).
  - CALC iterations occur at edges E1..E(WIDTH).
  - FIX occurs at edge E(WIDTH+1).
- After E(WIDTH+1): `busy`=0, `done`=1 for exactly one cycle, and `hi`/`lo` hold the result.
- Back-to-back: a new `start` may be sampled at E(WIDTH+2), in the cycle where `done`=1. Total issue interval is WIDTH+2 cycles.
- `busy`, `done`, `hi` and `lo` are registered outputs; none depends combinationally on any input.
- An MTHI/MTLO write in IDLE is visible on `hi`/`lo` the cycle after the edge that samples it.

## Test plan
- Reset: assert `rst` asynchronously between edges → `hi`=`lo`=0, `busy`=`done`=0 without waiting for a clock edge. Then MTHI 0x12345678 and MTLO 0x9ABCDEF0 in IDLE → `hi`=0x12345678 and `lo`=0x9ABCDEF0 next cycle.
- WIDTH=32 multiplies:
  - MULT a=0xFFFFFFFD (−3), b=7 → busy exactly 33 cycles (E0..E32), `done` single pulse after E33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
  - MULTU a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Divides:
  - DIV a=−7, b=2 → `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
  - DIVU a=7, b=2 → `lo`=3, `hi`=1.
  - DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Divide by zero: DIVU a=0x55, b=0 → after 34 cycles `hi`=0x55, `lo`=0xFFFFFFFF.
- Protocol:
  - `start` plus `hi_we` while busy, and mid-operation changes to `a`/`b` → no effect on the result, no restart.
  - `start` and `lo_we` in the same IDLE cycle → the multiply result wins and the write is lost.
  - Back-to-back start in the `done` cycle → second result is correct 34 cycles later.
- Reset mid-operation: `rst` at E10 → `busy`=0, `hi`=`lo`=0, no `done`. Then a second WIDTH=8 build runs MULT 0x80 × 0x80 → `hi`=0x40, `lo`=0x00, with a latency of 10 cycles.

Source files
------------

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             sa;
    logic             sb;
    logic             bz;
    logic [WIDTH:0]   opd;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] q;

    logic             sgn;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   a_mag;
    logic [WIDTH:0]   b_mag;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl;
    logic [WIDTH+1:0] diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;

    assign sgn   = ~op[0];
    assign a_ext = {sgn & a[WIDTH-1], a};
    assign b_ext = {sgn & b[WIDTH-1], b};
    assign a_mag = a_ext[WIDTH] ? -a_ext : a_ext;
    assign b_mag = b_ext[WIDTH] ? -b_ext : b_ext;

    // Multiply: {rem,q} is the product register; q starts as the multiplier and shifts right.
    assign sum  = rem + (q[0] ? opd : '0);

    // Divide: q starts as the dividend, shifts left collecting quotient bits.
    assign shl  = {rem[WIDTH-1:0], q[WIDTH-1]};
    assign diff = {1'b0, shl} - {1'b0, opd};

    assign prod   = {rem[WIDTH-1:0], q};
    assign prod_s = (sa ^ sb) ? -prod : prod;
    assign quo_s  = bz ? '1 : ((sa ^ sb) ? -q : q);
    assign rem_s  = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            bz     <= 1'b0;
            opd    <= '0;
            rem    <= '0;
            q      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        sa     <= sgn & a[WIDTH-1];
                        sb     <= sgn & b[WIDTH-1];
                        bz     <= op[1] & (b == '0);
                        opd    <= op[1] ? b_mag : a_mag;
                        q      <= op[1] ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0];
                        rem    <= '0;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem <= diff[WIDTH+1] ? shl : diff[WIDTH:0];
                        q   <= {q[WIDTH-2:0], ~diff[WIDTH+1]};
                    end else begin
                        rem <= {1'b0, sum[WIDTH:1]};
                        q   <= {sum[0], q[WIDTH-1:1]};
                    end
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_s;
                        lo <= quo_s;
                    end else begin
                        hi <= prod_s[2*WIDTH-1:WIDTH];
                        lo <= prod_s[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter at WIDTH=32 and WIDTH=8
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, hi_we, lo_we, busy, done;
    logic [1:0]  op;
    logic [31:0] a, b, wdata, hi, lo;

    logic        start8, busy8, done8, zero1;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, wdata8, hi8, lo8;

    logic [63:0] exp_q[$];
    logic [63:0] exp8_q[$];
    logic [63:0] e, e8;
    logic [31:0] m_hi, m_lo;
    logic        prev_done;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .hi_we(zero1), .lo_we(zero1), .wdata(wdata8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values, truncating division.
    function automatic void model(input int w, input logic [1:0] o, input logic [31:0] x,
                                  input logic [31:0] y, output logic [31:0] h, output logic [31:0] l);
        longint sx, sy, p, mask;
        mask = (longint'(1) << w) - 1;
        sx = longint'(x) & mask;
        sy = longint'(y) & mask;
        if (!o[0]) begin
            if (sx >= (longint'(1) << (w - 1))) sx -= (longint'(1) << w);
            if (sy >= (longint'(1) << (w - 1))) sy -= (longint'(1) << w);
        end
        if (!o[1]) begin
            p = sx * sy;
            h = 32'((p >>> w) & mask);
            l = 32'(p & mask);
        end else if (sy == 0) begin
            h = 32'(longint'(x) & mask);
            l = 32'(mask);
        end else begin
            h = 32'((sx % sy) & mask);
            l = 32'((sx / sy) & mask);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_done: done=1 with no result pending");
            end else begin
                e = exp_q.pop_front();
                chk("result_hi", hi, e[63:32]);
                chk("result_lo", lo, e[31:0]);
            end
            if (prev_done) begin
                n_cmp++; n_bad++;
                $display("FAIL done_width: done=1 for two cycles, required one");
            end
        end
        if (!rst && done8) begin
            if (exp8_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL spurious_done8: done=1 with no result pending");
            end else begin
                e8 = exp8_q.pop_front();
                chk("result8_hi", {24'd0, hi8}, e8[63:32]);
                chk("result8_lo", {24'd0, lo8}, e8[31:0]);
            end
        end
        prev_done = done;
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit noise, input bit wr_too);
        logic [31:0] h, l;
        int cnt;
        model(32, o, x, y, h, l);
        exp_q.push_back({h, l});
        op = o; a = x; b = y; start = 1'b1;
        if (wr_too) begin lo_we = 1'b1; wdata = $urandom; end
        @(posedge clk); #1;
        start = 1'b0; lo_we = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (busy && cnt < 100) begin
            cnt++;
            chk("hold_hi", hi, m_hi);
            chk("hold_lo", lo, m_lo);
            if (noise) begin
                a = $urandom; b = $urandom; op = 2'($urandom); wdata = $urandom;
                start = 1'($urandom); hi_we = 1'($urandom); lo_we = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        chk("busy_cycles", 32'(cnt), 32'd33);
        chk("done_pulse", {31'd0, done}, 32'd1);
        m_hi = h; m_lo = l;
    endtask

    task automatic run_op8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [31:0] h, l;
        int cnt;
        model(8, o, {24'd0, x}, {24'd0, y}, h, l);
        exp8_q.push_back({h, l});
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (busy8 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy8_cycles", 32'(cnt), 32'd9);
        chk("done8_pulse", {31'd0, done8}, 32'd1);
    endtask

    task automatic mt(input bit wh, input bit wl, input logic [31:0] d);
        hi_we = wh; lo_we = wl; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        chk("mt_hi", hi, m_hi);
        chk("mt_lo", lo, m_lo);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0; zero1 = 1'b0;
        start8 = 1'b0; op8 = 2'd0; a8 = '0; b8 = '0; wdata8 = '0;
        m_hi = '0; m_lo = '0; prev_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        mt(1'b1, 1'b0, 32'h12345678);
        mt(1'b0, 1'b1, 32'h9ABCDEF0);

        // asynchronous reset between edges
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        mt(1'b1, 1'b0, 32'h12345678);
        mt(1'b0, 1'b1, 32'h9ABCDEF0);
        mt(1'b1, 1'b1, 32'hCAFE0001);

        run_op(2'd0, 32'hFFFFFFFD, 32'd7, 1'b0, 1'b0);
        chk("mult_neg_hi", hi, 32'hFFFFFFFF);
        chk("mult_neg_lo", lo, 32'hFFFFFFEB);
        run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("multu_max_hi", hi, 32'hFFFFFFFE);
        chk("multu_max_lo", lo, 32'h00000001);
        run_op(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        run_op(2'd3, 32'd7, 32'd2, 1'b0, 1'b0);
        chk("divu_hi", hi, 32'd1);
        chk("divu_lo", lo, 32'd3);
        run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("div_ovf_hi", hi, 32'd0);
        chk("div_ovf_lo", lo, 32'h80000000);
        run_op(2'd3, 32'h55, 32'd0, 1'b0, 1'b0);
        chk("divu_zero_hi", hi, 32'h55);
        chk("divu_zero_lo", lo, 32'hFFFFFFFF);
        run_op(2'd2, 32'hFFFFFFF9, 32'd0, 1'b0, 1'b0);
        run_op(2'd0, 32'd1234567, 32'hFFFFFFA7, 1'b1, 1'b0);
        run_op(2'd2, 32'hFFF00001, 32'd13, 1'b1, 1'b0);
        run_op(2'd0, 32'd6, 32'd7, 1'b0, 1'b1);
        chk("start_wins_lo", lo, 32'd42);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFFFFFF;
                2:       ry = 32'($urandom_range(1, 9));
                default: ry = $urandom;
            endcase
            run_op(ro, rx, ry, 1'($urandom), 1'b0);
        end

        // reset mid-operation
        op = 2'd0; a = 32'd99; b = 32'd77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_idle_busy", {31'd0, busy}, 32'd0);

        run_op8(2'd0, 8'h80, 8'h80);
        chk("mult8_hi", {24'd0, hi8}, 32'h40);
        chk("mult8_lo", {24'd0, lo8}, 32'h00);
        for (int i = 0; i < 12; i++)
            run_op8(2'($urandom), ($urandom_range(0, 5) == 0) ? 8'h80 : 8'($urandom),
                    ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom));

        repeat (3) @(negedge clk);
        chk("queue32_empty", 32'(exp_q.size()), 32'd0);
        chk("queue8_empty", 32'(exp8_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
